// File: rtl/dma_stream_sequencer_if.sv
// Stream and engine-command signal bundle for dma_stream_sequencer.
// The sequencer takes the master view; the engine/stream environment takes the slave view.
interface dma_stream_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    logic                  o_cmd_s2mm_en;
    logic                  o_cmd_mm2s_en;
    logic [ADDR_WIDTH-1:0] o_cmd_addr;
    logic [DATA_WIDTH-1:0] o_cmd_data;
    logic                  i_cmd_done;
    logic [DATA_WIDTH-1:0] i_cmd_rdata;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output o_cmd_s2mm_en, o_cmd_mm2s_en, o_cmd_addr, o_cmd_data,
        input  i_cmd_done, i_cmd_rdata
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  o_cmd_s2mm_en, o_cmd_mm2s_en, o_cmd_addr, o_cmd_data,
        output i_cmd_done, i_cmd_rdata
    );
endinterface

// File: rtl/dma_stream_sequencer.sv
// Splits a base-address + word-count request into single-word engine commands, buffering
// S2MM stream data or MM2S read results in a small FIFO.
module dma_stream_sequencer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_dir,
    input  logic [ADDR_WIDTH-1:0]  i_base_addr,
    input  logic [LEN_WIDTH-1:0]   i_len_words,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_short,
    dma_stream_sequencer_if.master io_bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StDone} state_e;

    state_e                r_state, w_state_next;
    logic                  r_dir;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cmd_cnt;
    logic [LEN_WIDTH-1:0]  r_accept_cnt;
    logic                  r_accept_stop;
    logic                  r_short;
    logic [LEN_WIDTH-1:0]  r_pop_cnt;
    logic [DATA_WIDTH-1:0] r_cmd_data;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_start, w_empty, w_full;
    logic                  w_issue_wr, w_issue_rd, w_cmd_fin;
    logic                  w_s_beat, w_m_beat, w_push, w_pop;
    logic [DATA_WIDTH-1:0] w_head, w_push_data;
    logic [LEN_WIDTH-1:0]  w_accept_inc;

    assign w_start      = (r_state == StIdle) & i_start;
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_head       = r_mem[r_rd_ptr];
    assign w_accept_inc = r_accept_cnt + LEN_WIDTH'(1);

    assign o_busy  = (r_state != StIdle);
    assign o_done  = (r_state == StDone);
    assign o_short = r_short;

    assign io_bus.s_axis_tready = o_busy & ~r_dir & ~w_full & ~r_accept_stop;
    assign io_bus.m_axis_tvalid = r_dir & ~w_empty;
    assign io_bus.m_axis_tdata  = io_bus.m_axis_tvalid ? w_head : '0;
    assign io_bus.m_axis_tlast  = io_bus.m_axis_tvalid & (r_pop_cnt == r_len - LEN_WIDTH'(1));

    assign io_bus.o_cmd_s2mm_en = w_issue_wr;
    assign io_bus.o_cmd_mm2s_en = w_issue_rd;
    assign io_bus.o_cmd_addr    = r_addr;
    // The popped word is shown straight from the FIFO head on the pulse, then held.
    assign io_bus.o_cmd_data    = w_issue_wr ? w_head : r_cmd_data;

    assign w_s_beat    = io_bus.s_axis_tvalid & io_bus.s_axis_tready;
    assign w_m_beat    = io_bus.m_axis_tvalid & io_bus.m_axis_tready;
    assign w_push      = r_dir ? w_cmd_fin : w_s_beat;
    assign w_pop       = r_dir ? w_m_beat : w_issue_wr;
    assign w_push_data = r_dir ? io_bus.i_cmd_rdata : io_bus.s_axis_tdata;

    always_comb begin
        w_state_next = r_state;
        w_issue_wr   = 1'b0;
        w_issue_rd   = 1'b0;
        w_cmd_fin    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) w_state_next = (i_len_words == '0) ? StDone : StIssue;
            end
            StIssue: begin
                // MM2S only issues when the FIFO has a free slot for the result.
                if (!r_dir && !w_empty) begin
                    w_issue_wr   = 1'b1;
                    w_state_next = StWait;
                end else if (r_dir && !w_full) begin
                    w_issue_rd   = 1'b1;
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (io_bus.i_cmd_done) begin
                    w_cmd_fin = 1'b1;
                    if (r_cmd_cnt + LEN_WIDTH'(1) == r_len) begin
                        w_state_next = r_dir ? StDrain : StDone;
                    end else begin
                        w_state_next = StIssue;
                    end
                end
            end
            StDrain: begin
                if (w_empty) w_state_next = StDone;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_dir         <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_cmd_cnt     <= '0;
            r_accept_cnt  <= '0;
            r_accept_stop <= 1'b0;
            r_short       <= 1'b0;
            r_pop_cnt     <= '0;
            r_cmd_data    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_dir         <= i_dir;
                r_addr        <= i_base_addr;
                r_len         <= i_len_words;
                r_cmd_cnt     <= '0;
                r_accept_cnt  <= '0;
                r_accept_stop <= (i_len_words == '0);
                r_short       <= 1'b0;
                r_pop_cnt     <= '0;
            end else begin
                if (w_cmd_fin) begin
                    r_addr    <= r_addr + STRIDE;
                    r_cmd_cnt <= r_cmd_cnt + LEN_WIDTH'(1);
                end
                if (w_issue_wr) r_cmd_data <= w_head;
                if (w_s_beat) begin
                    r_accept_cnt <= w_accept_inc;
                    if (w_accept_inc == r_len) begin
                        r_accept_stop <= 1'b1;
                    end else if (io_bus.s_axis_tlast) begin
                        // Early tlast shrinks the transfer to the words actually received.
                        r_accept_stop <= 1'b1;
                        r_short       <= 1'b1;
                        r_len         <= w_accept_inc;
                    end
                end
                if (w_m_beat) r_pop_cnt <= r_pop_cnt + LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end
endmodule
